r2sdf_ctrl: RTL

Control sequencer for the radix-2 single-path delay-feedback (R2SDF) FFT pipeline. It gates sample flow into the `bf_stage` chain and drives each stage's butterfly/bypass select and twiddle index. It tags outputs with valid, frame-start and output-index information. After the last frame it flushes the pipeline through a drain phase. It sits between the sample source and the `N` cascaded `bf_stage` instances.

---
 rtl/r2sdf_pkg.sv | 39 +++
 rtl/r2sdf_tw_addr.sv | 38 +++
 rtl/r2sdf_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/r2sdf_pkg.sv
// Shared definitions for the R2SDF FFT control sequencer.
//   state_t       : controller state encoding (IDLE, RUN, DRAIN)
//   DELAY_TOTAL   : total pipeline latency in advances for an FFT of 2^n points
//   stage_offset  : count offset of stage s relative to the input counter
//   bitrev        : reverse the low n bits of a word (natural R2SDF output order)
package r2sdf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Widest index the bit-reverse helper supports.
   localparam int BITREV_W = 16;

   function automatic int DELAY_TOTAL(input int n);
      return int'((32'd1 << n) - 32'd1);
   endfunction

   // Stage s sees the sample stream 2^n - 2^(n-s+1) advances after stage 1.
   function automatic int stage_offset(input int n, input int s);
      return int'((32'd1 << n) - (32'd1 << (n - s + 1)));
   endfunction

   function automatic logic [BITREV_W-1:0] bitrev(input logic [BITREV_W-1:0] v, input int n);
      logic [BITREV_W-1:0] r;
      r = '0;
      for (int i = 0; i < BITREV_W; i++) begin
         if (i < n) begin
            r[i] = v[n-1-i];
         end else begin
            r[i] = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/r2sdf_tw_addr.sv
// Per-stage mode and twiddle address generator.
// Ports:
//   k      in  N  controller input counter (registered)
//   bf_sel out 1  stage mode: 0 fill/feedback, 1 butterfly
//   tw_idx out N  twiddle index (W_{2^N}) applied while in fill/feedback mode
// Parameters: N = log2 FFT size, S = stage number (1..N).
module r2sdf_tw_addr
   import r2sdf_pkg::*;
#(
   parameter int N = 3,
   parameter int S = 1
)
(
   input  logic [N-1:0] k,
   output logic         bf_sel,
   output logic [N-1:0] tw_idx
);

   localparam int           OFFSET_I = stage_offset(N, S);
   localparam logic [N-1:0] OFFSET_P = OFFSET_I[N-1:0];
   // Keeps the low N-S bits of the local count; zero for the last stage.
   localparam int           MASK_I   = int'((32'd1 << (N - S)) - 32'd1);
   localparam logic [N-1:0] MASK_P   = MASK_I[N-1:0];

   logic [N-1:0] c_s;

   // Local stage count, butterfly select and twiddle index (zero in butterfly mode).
   always_comb begin
      c_s    = k - OFFSET_P;
      bf_sel = c_s[N-S];
      if (c_s[N-S] == 1'b0) begin
         tw_idx = (c_s & MASK_P) << (S - 1);
      end else begin
         tw_idx = '0;
      end
   end

endmodule

// File: rtl/r2sdf_ctrl.sv
// Control sequencer for a radix-2 single-path delay-feedback FFT pipeline.
// Gates sample flow into the bf_stage chain, drives each stage's mode and
// twiddle index, tags outputs and drains the pipeline after the last frame.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   in_valid    source has a sample        in_ready   controller accepts it
//   flush       drain request (level), honoured at the next frame boundary
//   stage_en    advance enable for all stages
//   bf_sel      bit s-1 = stage s mode (0 fill/feedback, 1 butterfly)
//   tw_idx      packed N-bit twiddle indices, slice s-1 for stage s=1..N-1
//   out_valid   sample leaving stage N is real
//   out_first   out_valid for output index 0
//   out_idx     frequency index of the current output
// Build option: define R2SDF_CTRL_BITREV_EN to present out_idx in
// bit-reversed (natural R2SDF) order; otherwise out_idx is the raw count.
module r2sdf_ctrl
   import r2sdf_pkg::*;
#(
   parameter int N = 3
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   output logic               stage_en,
   output logic [N-1:0]       bf_sel,
   output logic [N*(N-1)-1:0] tw_idx,
   output logic               out_valid,
   output logic               out_first,
   output logic [N-1:0]       out_idx
);

   localparam int           L_I      = DELAY_TOTAL(N);
   localparam logic [N-1:0] L_P      = L_I[N-1:0];
   localparam int           L_LAST_I = L_I - 1;
   localparam logic [N-1:0] L_LAST_P = L_LAST_I[N-1:0];

   state_t       state_r;
   state_t       state_nxt_s;
   logic [N-1:0] k_r;
   logic [N-1:0] warm_r;
   logic [N-1:0] d_r;
   logic [N-1:0] o_r;
   logic         accept_s;
   logic         in_drain_s;
   logic         drain_done_s;
   logic [N-1:0] tw_last_unused_s;

   // Handshake, advance enable and output tagging, all combinational from state.
   always_comb begin
      in_drain_s   = (state_r == ST_DRAIN);
      in_ready     = ~in_drain_s;
      accept_s     = in_valid & ~in_drain_s;
      stage_en     = accept_s | in_drain_s;
      // During drain every advance pushes out a real sample still in flight.
      out_valid    = in_drain_s | (stage_en & (warm_r == L_P));
      out_first    = out_valid & (o_r == {N{1'b0}});
      drain_done_s = in_drain_s & (d_r == L_LAST_P);
   end

   // Output index presentation order.
   always_comb begin
`ifdef R2SDF_CTRL_BITREV_EN
      out_idx = N'(bitrev(BITREV_W'(o_r), N));
`else
      out_idx = o_r;
`endif
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // A flush only takes effect on a frame boundary with no new sample offered.
            if (flush && (k_r == {N{1'b0}}) && !in_valid) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (drain_done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Input, warm-up, drain and output counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_r    <= '0;
         warm_r <= '0;
         d_r    <= '0;
         o_r    <= '0;
      end else if (drain_done_s) begin
         k_r    <= '0;
         warm_r <= '0;
         d_r    <= '0;
         o_r    <= '0;
      end else begin
         if (stage_en) begin
            k_r <= k_r + 1'b1;
         end
         // warm saturates at L: from then on every advance emits a real sample.
         if (accept_s && (warm_r != L_P)) begin
            warm_r <= warm_r + 1'b1;
         end
         if (in_drain_s) begin
            d_r <= d_r + 1'b1;
         end
         if (out_valid) begin
            o_r <= o_r + 1'b1;
         end
      end
   end

   // Stages 1..N-1 carry a twiddle slice; the last stage only needs its mode bit.
   for (genvar s = 1; s < N; s++) begin : g_stage
      r2sdf_tw_addr #(.N(N), .S(s)) u_tw_addr (
         .k      (k_r),
         .bf_sel (bf_sel[s-1]),
         .tw_idx (tw_idx[(s-1)*N +: N])
      );
   end

   r2sdf_tw_addr #(.N(N), .S(N)) u_tw_addr_last (
      .k      (k_r),
      .bf_sel (bf_sel[N-1]),
      .tw_idx (tw_last_unused_s)
   );

endmodule
